// File: rtl/hdc_pkg.sv
// Shared HDC constants and types used by the encoder and the associative-memory search.
package hdc_pkg;

  localparam int HV_DIM      = 4096;
  localparam int DIMS_PER_CC = 1024;
  localparam int SEGS        = HV_DIM / DIMS_PER_CC;
  localparam int DIST_W      = $clog2(HV_DIM + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} am_state_t;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational population count built as a recursive binary adder tree.
module hdc_popcount #(
  parameter int  W  = 8,
  localparam int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [OW-1:0] count
);

  generate
    if (W == 1) begin : g_leaf
      assign count = data;
    end else begin : g_split
      localparam int LO    = W / 2;
      localparam int HI    = W - LO;
      localparam int LO_OW = $clog2(LO + 1);
      localparam int HI_OW = $clog2(HI + 1);

      logic [LO_OW-1:0] c_lo;
      logic [HI_OW-1:0] c_hi;

      hdc_popcount #(.W(LO)) u_lo (.data(data[LO-1:0]),  .count(c_lo));
      hdc_popcount #(.W(HI)) u_hi (.data(data[W-1:LO]),  .count(c_hi));

      assign count = OW'(c_lo) + OW'(c_hi);
    end
  endgenerate

endmodule

// File: rtl/hdc_am_search.sv
// Associative-memory search: streams every class HV segment-by-segment and reports
// the class with the minimum Hamming distance to the latched query.
module hdc_am_search #(
  parameter int  HV_DIM      = hdc_pkg::HV_DIM,
  parameter int  DIMS_PER_CC = hdc_pkg::DIMS_PER_CC,
  parameter int  NUM_CLASSES = 10,
  localparam int SEGS        = HV_DIM / DIMS_PER_CC,
  localparam int SEG_W       = hdc_pkg::clog2_min1(SEGS),
  localparam int CLASS_W     = hdc_pkg::clog2_min1(NUM_CLASSES),
  localparam int DIST_W      = $clog2(HV_DIM + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   query_valid,
  output logic                   query_ready,
  input  logic [HV_DIM-1:0]      encoded_hv,
  output logic                   class_rd_en,
  output logic [CLASS_W-1:0]     class_rd_addr,
  output logic [SEG_W-1:0]       class_rd_seg,
  input  logic [DIMS_PER_CC-1:0] class_rd_data,
  output logic                   pred_valid,
  input  logic                   pred_ready,
  output logic [CLASS_W-1:0]     pred_class,
  output logic [DIST_W-1:0]      pred_dist
);

  import hdc_pkg::*;

  localparam int PC_W = $clog2(DIMS_PER_CC + 1);

  am_state_t                state;
  logic [HV_DIM-1:0]        query;
  logic [DIST_W-1:0]        acc, best_dist, total, cand_dist;
  logic [CLASS_W-1:0]       best_class, cand_class, addr_d;
  logic [SEG_W-1:0]         seg_d;
  logic                     vld_d, last_seg_d;
  logic [DIMS_PER_CC-1:0]   q_seg, diff;
  logic [PC_W-1:0]          seg_dist;

  assign query_ready = (state == IDLE);
  assign class_rd_en = (state == SEARCH);
  assign pred_valid  = (state == DONE);

  // Read data returns one cycle after the strobe, so it pairs with the delayed indices.
  assign q_seg      = query[seg_d*DIMS_PER_CC +: DIMS_PER_CC];
  assign diff       = class_rd_data ^ q_seg;
  assign last_seg_d = (seg_d == SEG_W'(SEGS - 1));
  assign total      = acc + DIST_W'(seg_dist);

  hdc_popcount #(.W(DIMS_PER_CC)) u_pop (.data(diff), .count(seg_dist));

  // Strict compare keeps the lower class index on ties.
  always_comb begin
    cand_dist  = best_dist;
    cand_class = best_class;
    if (vld_d && last_seg_d && (total < best_dist)) begin
      cand_dist  = total;
      cand_class = addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      query         <= '0;
      acc           <= '0;
      best_dist     <= '0;
      best_class    <= '0;
      vld_d         <= 1'b0;
      seg_d         <= '0;
      addr_d        <= '0;
      class_rd_addr <= '0;
      class_rd_seg  <= '0;
      pred_class    <= '0;
      pred_dist     <= '0;
    end else begin
      vld_d      <= class_rd_en;
      seg_d      <= class_rd_seg;
      addr_d     <= class_rd_addr;
      best_dist  <= cand_dist;
      best_class <= cand_class;
      if (vld_d) acc <= last_seg_d ? '0 : total;

      case (state)
        IDLE: begin
          if (query_valid) begin
            query     <= encoded_hv;
            acc       <= '0;
            best_dist <= '1;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (class_rd_seg == SEG_W'(SEGS - 1)) begin
            class_rd_seg <= '0;
            if (class_rd_addr == CLASS_W'(NUM_CLASSES - 1)) begin
              class_rd_addr <= '0;
              state         <= DRAIN;
            end else begin
              class_rd_addr <= class_rd_addr + 1'b1;
            end
          end else begin
            class_rd_seg <= class_rd_seg + 1'b1;
          end
        end
        DRAIN: begin
          pred_class <= cand_class;
          pred_dist  <= cand_dist;
          state      <= DONE;
        end
        DONE: begin
          if (pred_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
